// File: rtl/fm_mod_core.sv
// FM modulator: soft-muted audio deviates a phase-accumulator carrier that indexes a sine ROM.
// Latency: an accepted sample reaches rf four edges later. The sample input is always ready when rst is low.
// Optional FM_DITHER_EN adds LFSR phase dither ahead of the table lookup. N-M must not exceed 16.
module fm_mod_core #(
    parameter int A = 8,
    parameter int L = 12,
    parameter int N = 18,
    parameter int M = 5,
    parameter int D = 4,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [A-1:0] audio,
    input  logic         audio_valid,
    output logic         audio_ready,
    input  logic [N-1:0] acc_inc,
    input  logic [L-1:0] df_inc,
    input  logic         enable,
    input  logic [2:0]   dith_fact,
    output logic [D-1:0] rf,
    output logic         rf_valid,
    output logic [1:0]   state
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RAMP_UP   = 2'd1;
    localparam logic [1:0] RUN       = 2'd2;
    localparam logic [1:0] RAMP_DOWN = 2'd3;

    localparam logic [R:0]   GAIN_FULL = {1'b1, {R{1'b0}}};
    localparam logic [R:0]   GAIN_ONE  = {{R{1'b0}}, 1'b1};
    localparam logic [D-1:0] RF_MID    = {1'b1, {(D-1){1'b0}}};

    generate
        if (N - M > 16) begin : g_bad_width
            $error("fm_mod_core: N-M must not exceed 16");
        end
    endgenerate

    function automatic logic [D-1:0] sine_val(input int idx);
        real x;
        x = ((2.0 ** D) - 1.0) / 2.0 * (1.0 + $sin(2.0 * 3.14159265358979 * idx / (2.0 ** M)));
        return D'($rtoi(x + 0.5));
    endfunction

    logic [D-1:0] sine_rom [2**M];
    generate
        for (genvar i = 0; i < 2**M; i++) begin : g_rom
            assign sine_rom[i] = sine_val(i);
        end
    endgenerate

    logic                  accept;
    logic [R:0]            gain;
    logic signed [A-1:0]   sample;
    logic signed [A+R+1:0] prod_g;
    logic signed [A-1:0]   scaled;
    logic signed [A+L:0]   prod_d;
    logic [N-1:0]          dev;
    logic [N-1:0]          fw;
    logic [N-1:0]          phase;
    logic [N-1:0]          dither;
    logic [M-1:0]          addr;

    assign accept = audio_valid & ~rst;

    // Gain is at most 2^R, so the scaled sample always fits back into A bits.
    always_comb begin
        prod_g = (A+R+2)'(sample) * (A+R+2)'($signed({1'b0, gain}));
        scaled = A'(prod_g >>> R);
        prod_d = (A+L+1)'(scaled) * (A+L+1)'($signed({1'b0, df_inc}));
        dev    = N'(prod_d >>> (A-1));
    end

`ifdef FM_DITHER_EN
    logic [15:0]    lfsr;
    logic [N-M-1:0] dith_raw;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_comb begin
        dith_raw = '0;
        if (dith_fact != 3'd0) dith_raw = lfsr[N-M-1:0] >> (3'd7 - dith_fact);
        dither = N'(dith_raw);
    end
`else
    logic unused_dith;
    assign unused_dith = ^dith_fact;
    assign dither      = '0;
`endif

    assign addr = M'((phase + dither) >> (N-M));

    // Gain moves only on accepted samples; enable changes redirect the ramp without touching gain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gain        <= '0;
            sample      <= '0;
            audio_ready <= 1'b0;
        end else begin
            audio_ready <= 1'b1;
            if (accept) sample <= $signed(audio);
            case (state)
                IDLE: if (enable) state <= RAMP_UP;
                RAMP_UP: begin
                    if (!enable) begin
                        state <= RAMP_DOWN;
                    end else if (accept) begin
                        gain <= gain + GAIN_ONE;
                        if (gain + GAIN_ONE == GAIN_FULL) state <= RUN;
                    end
                end
                RUN: if (!enable) state <= RAMP_DOWN;
                default: begin
                    if (enable) begin
                        state <= RAMP_UP;
                    end else if (gain == '0) begin
                        state <= IDLE;
                    end else if (accept) begin
                        gain <= gain - GAIN_ONE;
                        if (gain == GAIN_ONE) state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fw       <= '0;
            phase    <= '0;
            rf       <= RF_MID;
            rf_valid <= 1'b0;
        end else begin
            fw       <= acc_inc + dev;
            phase    <= (state == IDLE) ? '0 : phase + fw;
            rf       <= (state == IDLE) ? RF_MID : sine_rom[addr];
            rf_valid <= (state != IDLE);
        end
    end

endmodule

// File: tb/tb_fm_mod_core.sv
// Self-checking bench for fm_mod_core with a behavioural FM/sine reference model.
module tb_fm_mod_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  audio;
    logic        audio_valid;
    logic        audio_ready;
    logic [17:0] acc_inc;
    logic [11:0] df_inc;
    logic        enable;
    logic [2:0]  dith_fact;
    logic [3:0]  rf;
    logic        rf_valid;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    logic [3:0] cap [16];

    fm_mod_core dut (
        .clk(clk), .rst(rst), .audio(audio), .audio_valid(audio_valid),
        .audio_ready(audio_ready), .acc_inc(acc_inc), .df_inc(df_inc),
        .enable(enable), .dith_fact(dith_fact), .rf(rf), .rf_valid(rf_valid),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_rf(input int addr);
        real x;
        x = 7.5 * (1.0 + $sin(2.0 * 3.14159265358979 * addr / 32.0));
        return $rtoi(x + 0.5);
    endfunction

    function automatic logic [17:0] model_step(input int a, input int g, input int df, input int acc);
        int dv;
        dv = floor_div(floor_div(a * g, 16) * df, 128);
        return 18'(acc + dv);
    endfunction

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; audio_valid = 1'b0; audio = '0;
        acc_inc = '0; df_inc = '0; dith_fact = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; audio_valid = 1'b1; audio = 8'h55;
        acc_inc = 18'h1234; df_inc = 12'h321; dith_fact = 3'd5;
        tick(); tick();
        checks++; if (rf !== 4'd8) begin errors++; $display("FAIL reset_rf got %0d want 8", rf); end
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL reset_rf_valid got %0b want 0", rf_valid); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (audio_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", audio_ready); end
        rst = 1'b0; enable = 1'b0; audio_valid = 1'b0;
        tick();
        checks++; if (audio_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %0b want 1", audio_ready); end
    endtask

    // Starts a carrier with silent audio and records 16 rf samples from the first valid one.
    task automatic run_carrier(input logic [17:0] inc, input logic [2:0] df, input string nm);
        int  k;
        logic [17:0] ph;
        int  exp_v, got_v;
        do_reset();
        enable = 1'b1; audio = '0; audio_valid = 1'b1; acc_inc = inc;
        df_inc = 12'($urandom); dith_fact = df;
        k = 0;
        while (rf_valid !== 1'b1 && k < 10) begin tick(); k++; end
        checks++;
        if (rf_valid !== 1'b1) begin errors++; $display("FAIL %s_start rf_valid got %0b want 1", nm, rf_valid); end
        ph = '0;
        for (int i = 0; i < 16; i++) begin
            cap[i] = rf;
            exp_v = model_rf(int'(ph >> 13));
            got_v = int'(rf);
            checks++;
            if (got_v > exp_v + 1 || got_v < exp_v - 1)
                begin errors++; $display("FAIL %s_rf[%0d] got %0d want %0d+-1", nm, i, got_v, exp_v); end
            checks++;
            if (rf_valid !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d] got %0b want 1", nm, i, rf_valid); end
            ph = ph + inc;
            tick();
        end
    endtask

    task automatic test_carrier();
        run_carrier(18'h08000, 3'd0, "carrier");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== cap[i+8]) begin errors++; $display("FAIL carrier_period[%0d] got %0d want %0d", i, cap[i+8], cap[i]); end
        end
    endtask

    task automatic test_ramp();
        do_reset();
        enable = 1'b1; audio_valid = 1'b0;
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL ramp_enter state got %0d want 1", state); end
        for (int i = 1; i <= 16; i++) begin
            audio = 8'($urandom); audio_valid = 1'b1;
            tick();
            checks++;
            if (dut.gain !== 5'(i)) begin errors++; $display("FAIL ramp_gain got %0d want %0d", dut.gain, i); end
            checks++;
            if (state !== ((i == 16) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL ramp_state[%0d] got %0d want %0d", i, state, (i == 16) ? 2 : 1); end
            audio_valid = 1'b0;
            tick(); tick();
            checks++;
            if (dut.gain !== 5'(i) || state !== ((i == 16) ? 2'd2 : 2'd1))
                begin errors++; $display("FAIL ramp_hold[%0d] got gain %0d state %0d want gain %0d", i, dut.gain, state, i); end
        end
    endtask

    task automatic test_abort();
        do_reset();
        enable = 1'b1; audio_valid = 1'b0;
        tick();
        audio_valid = 1'b1;
        repeat (5) tick();
        enable = 1'b0; audio_valid = 1'b0;
        tick();
        checks++;
        if (state !== 2'd3 || dut.gain !== 5'd5) begin errors++; $display("FAIL abort_enter got state %0d gain %0d want state 3 gain 5", state, dut.gain); end
        audio_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (dut.gain !== 5'(5 - i) || state !== ((i == 5) ? 2'd0 : 2'd3))
                begin errors++; $display("FAIL abort_down[%0d] got gain %0d state %0d want gain %0d", i, dut.gain, state, 5 - i); end
        end
        tick();
        checks++; if (rf !== 4'd8) begin errors++; $display("FAIL abort_rf got %0d want 8", rf); end
        checks++; if (rf_valid !== 1'b0) begin errors++; $display("FAIL abort_rf_valid got %0b want 0", rf_valid); end
    endtask

    task automatic check_steps(input logic [7:0] a, input logic [11:0] df, input logic [17:0] acc, input string nm);
        logic [17:0] p0, p1, want;
        audio = a; df_inc = df; acc_inc = acc; audio_valid = 1'b1;
        repeat (4) tick();
        want = model_step(int'($signed(a)), 16, int'(df), int'(acc));
        for (int i = 0; i < 3; i++) begin
            p0 = dut.phase;
            tick();
            p1 = dut.phase;
            checks++;
            if (18'(p1 - p0) !== want) begin errors++; $display("FAIL %s_step got %05h want %05h", nm, 18'(p1 - p0), want); end
        end
    endtask

    task automatic test_deviation();
        do_reset();
        enable = 1'b1; audio = '0; audio_valid = 1'b1; acc_inc = 18'h08000; df_inc = 12'h100;
        repeat (17) tick();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL dev_run state got %0d want 2", state); end
        check_steps(8'h80, 12'h100, 18'h08000, "dev_neg");
        check_steps(8'h7F, 12'h100, 18'h08000, "dev_pos");
        check_steps(8'h80, 12'hFFF, 18'h3FF00, "dev_wrap");
        for (int n = 0; n < 12; n++)
            check_steps(8'($urandom), 12'($urandom), 18'($urandom), "dev_rand");
    endtask

    task automatic test_reset_mid_run();
        rst = 1'b1;
        tick();
        checks++;
        if (state !== 2'd0 || dut.gain !== 5'd0 || rf !== 4'd8 || rf_valid !== 1'b0)
            begin errors++; $display("FAIL midrun_reset got state %0d gain %0d rf %0d valid %0b", state, dut.gain, rf, rf_valid); end
        rst = 1'b0;
    endtask

    task automatic test_dither();
        logic [17:0] inc;
        inc = 18'($urandom_range(1, 18'h3FFFF));
`ifdef FM_DITHER_EN
        run_carrier(inc, 3'd0, "dither0");
`else
        run_carrier(inc, 3'd7, "dither7");
`endif
    endtask

    initial begin
        test_reset();
        test_carrier();
        test_ramp();
        test_abort();
        test_deviation();
        test_reset_mid_run();
        test_dither();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
